// File: rtl/brtag_alloc.sv
// brtag_alloc: branch-tag allocator with dependency tracking and mispredict recovery.
// Ports: i_clk/i_rst_n (async active-low reset); i_alloc_req -> o_alloc_gnt,
//   o_alloc_tag (one-hot), o_alloc_mask (dependency brmask); o_full;
//   i_res_valid/i_res_tag/i_res_kill resolve input; registered o_kill_valid,
//   o_kill_mask, o_clr_mask; o_busy (recovery window); o_live (allocated tags).
// Option: define BRTAG_FREE_BYPASS_EN to let a tag resolved correctly this cycle
//   be re-granted in the same cycle.
module brtag_alloc #(
  parameter int WIDTH_BRM   = 4,
  parameter int RECOVER_LAT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alloc_req,
  output logic                 o_alloc_gnt,
  output logic [WIDTH_BRM-1:0] o_alloc_tag,
  output logic [WIDTH_BRM-1:0] o_alloc_mask,
  output logic                 o_full,
  input  logic                 i_res_valid,
  input  logic [WIDTH_BRM-1:0] i_res_tag,
  input  logic                 i_res_kill,
  output logic                 o_kill_valid,
  output logic [WIDTH_BRM-1:0] o_kill_mask,
  output logic [WIDTH_BRM-1:0] o_clr_mask,
  output logic                 o_busy,
  output logic [WIDTH_BRM-1:0] o_live
);
  localparam int CNT_W = $clog2(RECOVER_LAT + 1);
  typedef enum logic {RUN, RECOVER} state_t;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH_BRM-1:0] r_live;
  logic [WIDTH_BRM-1:0] r_dep [WIDTH_BRM];
  logic                 w_res_hit;
  logic                 w_kill;
  logic [WIDTH_BRM-1:0] w_clr;
  logic [WIDTH_BRM-1:0] w_avail;
  logic [WIDTH_BRM-1:0] w_pick;
  logic [WIDTH_BRM-1:0] w_killset;
  assign w_res_hit = i_res_valid & |(i_res_tag & r_live);
  assign w_kill    = w_res_hit & i_res_kill;
  assign w_clr     = (w_res_hit & ~i_res_kill) ? i_res_tag : '0;
`ifdef BRTAG_FREE_BYPASS_EN
  assign w_avail = ~(r_live & ~w_clr);
`else
  assign w_avail = ~r_live;
`endif
  // isolate the lowest set bit of the free vector
  assign w_pick       = w_avail & (~w_avail + WIDTH_BRM'(1));
  assign o_full       = (r_state == RECOVER) | ~|w_avail;
  assign o_alloc_gnt  = i_alloc_req & ~o_full & ~(i_res_valid & i_res_kill);
  assign o_alloc_tag  = o_alloc_gnt ? w_pick : '0;
  assign o_alloc_mask = o_alloc_gnt ? (r_live & ~w_clr) : '0;
  assign o_busy       = (r_state == RECOVER);
  assign o_live       = r_live;
  // killed set: the mispredicted tag plus every live branch that depends on it
  always_comb begin
    w_killset = w_kill ? i_res_tag : '0;
    for (int j = 0; j < WIDTH_BRM; j++)
      if (w_kill && r_live[j] && |(r_dep[j] & i_res_tag)) w_killset[j] = 1'b1;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= RUN;
      r_cnt        <= '0;
      r_live       <= '0;
      o_kill_valid <= 1'b0;
      o_kill_mask  <= '0;
      o_clr_mask   <= '0;
      for (int j = 0; j < WIDTH_BRM; j++) r_dep[j] <= '0;
    end else begin
      r_live       <= (r_live & ~w_killset & ~w_clr) | o_alloc_tag;
      o_kill_valid <= w_kill;
      o_kill_mask  <= w_killset;
      o_clr_mask   <= w_clr;
      for (int j = 0; j < WIDTH_BRM; j++)
        r_dep[j] <= w_killset[j] ? '0 : o_alloc_tag[j] ? o_alloc_mask : (r_dep[j] & ~w_killset & ~w_clr);
      if (w_kill) begin
        r_state <= RECOVER;
        r_cnt   <= CNT_W'(RECOVER_LAT);
      end else if (r_state == RECOVER) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) r_state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_brtag_alloc.sv
// tb_brtag_alloc: directed self-checking bench for brtag_alloc.
module tb_brtag_alloc;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_req = 1'b0;
  logic       alloc_gnt;
  logic [3:0] alloc_tag;
  logic [3:0] alloc_mask;
  logic       full;
  logic       res_valid = 1'b0;
  logic [3:0] res_tag = '0;
  logic       res_kill = 1'b0;
  logic       kill_valid;
  logic [3:0] kill_mask;
  logic [3:0] clr_mask;
  logic       busy;
  logic [3:0] live;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  brtag_alloc #(.WIDTH_BRM(4), .RECOVER_LAT(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alloc_req(alloc_req), .o_alloc_gnt(alloc_gnt), .o_alloc_tag(alloc_tag),
    .o_alloc_mask(alloc_mask), .o_full(full),
    .i_res_valid(res_valid), .i_res_tag(res_tag), .i_res_kill(res_kill),
    .o_kill_valid(kill_valid), .o_kill_mask(kill_mask), .o_clr_mask(clr_mask),
    .o_busy(busy), .o_live(live)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    alloc_req = 1'b0;
    res_valid = 1'b0;
    res_kill = 1'b0;
    res_tag = '0;
    #2;
    chk("rst_live", {4'b0, live}, 8'h0);
    chk("rst_full", {7'b0, full}, 8'h0);
    chk("rst_busy", {7'b0, busy}, 8'h0);
    chk("rst_kv", {7'b0, kill_valid}, 8'h0);
    chk("rst_km", {4'b0, kill_mask}, 8'h0);
    chk("rst_clr", {4'b0, clr_mask}, 8'h0);
    tick();
    rst_n = 1'b1;
  endtask
  task automatic grant(input logic [3:0] tag, input logic [3:0] mask);
    alloc_req = 1'b1;
    #1;
    chk("gnt", {7'b0, alloc_gnt}, 8'h1);
    chk("gnt_tag", {4'b0, alloc_tag}, {4'b0, tag});
    chk("gnt_mask", {4'b0, alloc_mask}, {4'b0, mask});
    tick();
    alloc_req = 1'b0;
  endtask
  initial begin
    #1;
    do_reset();
    grant(4'b0001, 4'b0000);
    grant(4'b0010, 4'b0001);
    grant(4'b0100, 4'b0011);
    grant(4'b1000, 4'b0111);
    alloc_req = 1'b1;
    #1;
    chk("full_gnt", {7'b0, alloc_gnt}, 8'h0);
    chk("full_flag", {7'b0, full}, 8'h1);
    chk("full_tag", {4'b0, alloc_tag}, 8'h0);
    chk("full_live", {4'b0, live}, 8'hf);
    alloc_req = 1'b0;
    // correct resolve of 0010 from a full pool
    res_valid = 1'b1; res_tag = 4'b0010; res_kill = 1'b0;
    tick();
    res_valid = 1'b0;
    chk("clr_mask", {4'b0, clr_mask}, 8'b0010);
    chk("clr_live", {4'b0, live}, 8'b1101);
    chk("clr_kv", {7'b0, kill_valid}, 8'h0);
    grant(4'b0010, 4'b1101);
    chk("clr_pulse", {4'b0, clr_mask}, 8'h0);
    chk("clr_relive", {4'b0, live}, 8'hf);
    // kill 0010 with tags allocated in order
    do_reset();
    grant(4'b0001, 4'b0000);
    grant(4'b0010, 4'b0001);
    grant(4'b0100, 4'b0011);
    grant(4'b1000, 4'b0111);
    res_valid = 1'b1; res_tag = 4'b0010; res_kill = 1'b1;
    tick();
    res_valid = 1'b0; res_kill = 1'b0;
    chk("kill_valid", {7'b0, kill_valid}, 8'h1);
    chk("kill_mask", {4'b0, kill_mask}, 8'b1110);
    chk("kill_live", {4'b0, live}, 8'b0001);
    chk("kill_busy1", {7'b0, busy}, 8'h1);
    alloc_req = 1'b1;
    #1;
    chk("rec_full1", {7'b0, full}, 8'h1);
    chk("rec_gnt1", {7'b0, alloc_gnt}, 8'h0);
    tick();
    chk("kill_pulse", {7'b0, kill_valid}, 8'h0);
    chk("kill_busy2", {7'b0, busy}, 8'h1);
    chk("rec_gnt2", {7'b0, alloc_gnt}, 8'h0);
    tick();
    chk("rec_done", {7'b0, busy}, 8'h0);
    grant(4'b0010, 4'b0001);
    chk("rec_live", {4'b0, live}, 8'b0011);
    // request and kill of 0001 in the same cycle
    alloc_req = 1'b1; res_valid = 1'b1; res_tag = 4'b0001; res_kill = 1'b1;
    #1;
    chk("akill_gnt", {7'b0, alloc_gnt}, 8'h0);
    chk("akill_tag", {4'b0, alloc_tag}, 8'h0);
    tick();
    alloc_req = 1'b0; res_valid = 1'b0; res_kill = 1'b0;
    chk("akill_mask", {4'b0, kill_mask}, 8'b0011);
    chk("akill_live", {4'b0, live}, 8'h0);
    chk("akill_busy", {7'b0, busy}, 8'h1);
    // reset in the middle of the recovery window
    do_reset();
    grant(4'b0001, 4'b0000);
    // resolve of a tag that is not live is ignored
    res_valid = 1'b1; res_tag = 4'b0100; res_kill = 1'b1;
    tick();
    res_valid = 1'b0; res_kill = 1'b0;
    chk("nl_kv", {7'b0, kill_valid}, 8'h0);
    chk("nl_busy", {7'b0, busy}, 8'h0);
    chk("nl_live", {4'b0, live}, 8'b0001);
    // full pool plus correct resolve of 0100 and a request together
    grant(4'b0010, 4'b0001);
    grant(4'b0100, 4'b0011);
    grant(4'b1000, 4'b0111);
    alloc_req = 1'b1; res_valid = 1'b1; res_tag = 4'b0100; res_kill = 1'b0;
`ifdef BRTAG_FREE_BYPASS_EN
    #1;
    chk("byp_gnt", {7'b0, alloc_gnt}, 8'h1);
    chk("byp_tag", {4'b0, alloc_tag}, 8'b0100);
    chk("byp_mask", {4'b0, alloc_mask}, 8'b1011);
    tick();
    alloc_req = 1'b0; res_valid = 1'b0;
    chk("byp_clr", {4'b0, clr_mask}, 8'b0100);
    chk("byp_live", {4'b0, live}, 8'hf);
`else
    #1;
    chk("nbyp_gnt", {7'b0, alloc_gnt}, 8'h0);
    chk("nbyp_full", {7'b0, full}, 8'h1);
    tick();
    res_valid = 1'b0;
    chk("nbyp_clr", {4'b0, clr_mask}, 8'b0100);
    grant(4'b0100, 4'b1011);
    chk("nbyp_live", {4'b0, live}, 8'hf);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
